ysyx_22041412_csr_ctrl: RTL and testbench

- Issue/sequencing stage between the execute stage and the machine-mode CSR file.
- Accepts one CSR, ECALL or MRET instruction at a time and translates its 12-bit CSR address to the CSR file's 4-bit index.
- Drives the CSR file's two-phase en/valid_i/ready_o handshake, captures the returned value, and presents a write-back result plus an optional PC redirect to the downstream stage.

---
 rtl/ysyx_22041412_csr_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_ysyx_22041412_csr_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041412_csr_ctrl.sv
// ysyx_22041412_csr_ctrl
// Issue/sequencing stage between execute and the machine-mode CSR file.
// It takes one CSR, ECALL or MRET instruction at a time and maps the 12-bit
// CSR address onto the CSR file's 4-bit index. It then runs the two-phase
// en/valid_i/ready_o handshake and presents the result to the next stage.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | in_ready=1; an offered instruction is decoded and latched
// REQ   | csr_en=1, waiting for csr_ready; abort after TIMEOUT cycles
// ACK   | csr_en=1, csr_valid=1 for one cycle; CSR file commits, rdata captured
// DONE  | out_valid=1, results held until out_ready
module ysyx_22041412_csr_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_pc,
    input  logic [2:0]  in_func3,
    input  logic [11:0] in_csr,
    input  logic [63:0] in_rs1,
    input  logic [4:0]  in_zimm,
    input  logic        in_ecall,
    input  logic        in_mret,

    output logic        csr_en,
    output logic [63:0] csr_pc,
    output logic [3:0]  csr_addr,
    output logic [2:0]  csr_func3,
    output logic [63:0] csr_wdata,
    output logic        csr_valid,
    input  logic [63:0] csr_rdata,
    input  logic        csr_ready,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_rdata,
    output logic        out_redir,
    output logic [63:0] out_redir_pc,
    output logic        out_illegal,
    output logic        out_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Pseudo-CSR indices the CSR file uses for trap entry and trap return.
    localparam logic [3:0]      IDX_ECALL = 4'd10;
    localparam logic [3:0]      IDX_MRET  = 4'd11;
    // The counter is 0 on the first REQ cycle, so TIMEOUT-1 marks the last one.
    localparam logic [TO_W-1:0] CNT_LAST  = TO_W'(TIMEOUT - 1);

    state_t          state;
    state_t          state_nxt;
    logic [TO_W-1:0] cnt;

    // Decoded view of the offered instruction.
    logic [3:0]  dec_idx;
    logic        dec_hit;
    logic        dec_sys;
    logic [3:0]  dec_addr;
    logic [2:0]  dec_func3;
    logic [63:0] dec_wdata;
    logic        dec_illegal;

    // Latched request.
    logic [63:0] req_pc;
    logic [3:0]  req_addr;
    logic [2:0]  req_func3;
    logic [63:0] req_wdata;
    logic        req_sys;

    // Result registers.
    logic [63:0] res_rdata;
    logic        res_redir;
    logic [63:0] res_redir_pc;
    logic        res_illegal;
    logic        res_timeout;

    logic        accept;
    logic        req_expired;
    logic        release_out;

    // CSR address map: only the machine-mode trap CSRs exist in the CSR file.
    always_comb begin
        dec_idx = 4'd0;
        dec_hit = 1'b1;
        case (in_csr)
            12'h300: dec_idx = 4'd1;
            12'h304: dec_idx = 4'd2;
            12'h305: dec_idx = 4'd3;
            12'h341: dec_idx = 4'd4;
            12'h342: dec_idx = 4'd5;
            12'h344: dec_idx = 4'd6;
            default: dec_hit = 1'b0;
        endcase
    end

    // Instruction classification. ECALL wins when both ECALL and MRET are flagged.
    always_comb begin
        dec_sys     = in_ecall | in_mret;
        dec_addr    = in_ecall ? IDX_ECALL : (in_mret ? IDX_MRET : dec_idx);
        dec_func3   = dec_sys ? 3'b000 : in_func3;
        dec_wdata   = in_func3[2] ? {59'd0, in_zimm} : in_rs1;
        dec_illegal = !dec_sys && ((in_func3 == 3'b000) || !dec_hit);
    end

    assign accept      = (state == ST_IDLE) && in_valid;
    assign req_expired = (state == ST_REQ) && !csr_ready && (cnt == CNT_LAST);
    assign release_out = (state == ST_DONE) && out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt = dec_illegal ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (csr_ready) begin
                    state_nxt = ST_ACK;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_ACK: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        in_ready  = 1'b0;
        csr_en    = 1'b0;
        csr_valid = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_REQ:  csr_en   = 1'b1;
            ST_ACK: begin
                csr_en    = 1'b1;
                csr_valid = 1'b1;
            end
            ST_DONE: out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // REQ cycle counter; it stays at its final value until the result is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == ST_REQ) begin
            cnt <= cnt + TO_W'(1);
        end else if (release_out) begin
            cnt <= '0;
        end
    end

    // Request latch, written only on accept so the CSR file sees stable fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pc    <= 64'd0;
            req_addr  <= 4'd0;
            req_func3 <= 3'd0;
            req_wdata <= 64'd0;
            req_sys   <= 1'b0;
        end else if (accept) begin
            req_pc    <= in_pc;
            req_addr  <= dec_addr;
            req_func3 <= dec_func3;
            req_wdata <= dec_wdata;
            req_sys   <= dec_sys;
        end
    end

    // Result capture; cleared on accept so each instruction starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_rdata    <= 64'd0;
            res_redir    <= 1'b0;
            res_redir_pc <= 64'd0;
            res_illegal  <= 1'b0;
            res_timeout  <= 1'b0;
        end else if (accept) begin
            res_rdata    <= 64'd0;
            res_redir    <= 1'b0;
            res_redir_pc <= 64'd0;
            res_illegal  <= dec_illegal;
            res_timeout  <= 1'b0;
        end else if (state == ST_ACK) begin
            // Trap entry/return reads back mtvec/mepc as the redirect target.
            res_rdata    <= req_sys ? 64'd0 : csr_rdata;
            res_redir    <= req_sys;
            res_redir_pc <= req_sys ? csr_rdata : 64'd0;
        end else if (req_expired) begin
            res_timeout  <= 1'b1;
        end
    end

    assign csr_pc       = req_pc;
    assign csr_addr     = req_addr;
    assign csr_func3    = req_func3;
    assign csr_wdata    = req_wdata;

    assign out_rdata    = res_rdata;
    assign out_redir    = res_redir;
    assign out_redir_pc = res_redir_pc;
    assign out_illegal  = res_illegal;
    assign out_timeout  = res_timeout;

endmodule

// File: tb/tb_ysyx_22041412_csr_ctrl.sv
// Bench for ysyx_22041412_csr_ctrl with a small CSR file responder and a
// scoreboard of expected results.
module tb_ysyx_22041412_csr_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_pc = '0;
    logic [2:0]  in_func3 = '0;
    logic [11:0] in_csr = '0;
    logic [63:0] in_rs1 = '0;
    logic [4:0]  in_zimm = '0;
    logic        in_ecall = 1'b0;
    logic        in_mret = 1'b0;
    logic        csr_en;
    logic [63:0] csr_pc;
    logic [3:0]  csr_addr;
    logic [2:0]  csr_func3;
    logic [63:0] csr_wdata;
    logic        csr_valid;
    logic [63:0] csr_rdata;
    logic        csr_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_rdata;
    logic        out_redir;
    logic [63:0] out_redir_pc;
    logic        out_illegal;
    logic        out_timeout;

    ysyx_22041412_csr_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_func3(in_func3), .in_csr(in_csr), .in_rs1(in_rs1),
        .in_zimm(in_zimm), .in_ecall(in_ecall), .in_mret(in_mret),
        .csr_en(csr_en), .csr_pc(csr_pc), .csr_addr(csr_addr),
        .csr_func3(csr_func3), .csr_wdata(csr_wdata), .csr_valid(csr_valid),
        .csr_rdata(csr_rdata), .csr_ready(csr_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_redir(out_redir), .out_redir_pc(out_redir_pc),
        .out_illegal(out_illegal), .out_timeout(out_timeout)
    );

    always #5 clk = ~clk;

    // CSR file responder: ready during the request phase, commit on the valid phase.
    logic        resp_en = 1'b1;
    logic        mem_init = 1'b1;
    logic [63:0] csr_mem [0:15];

    assign csr_ready = csr_en & ~csr_valid & resp_en;

    always_comb begin
        if (csr_addr == 4'd10)      csr_rdata = csr_mem[3];
        else if (csr_addr == 4'd11) csr_rdata = csr_mem[4];
        else                        csr_rdata = csr_mem[csr_addr];
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) csr_mem[i] <= 64'd0;
            csr_mem[1] <= 64'ha00001800;
        end else if (csr_en && csr_valid) begin
            if (csr_addr == 4'd10) begin
                csr_mem[4] <= csr_pc;
            end else if (csr_addr != 4'd11) begin
                case (csr_func3[1:0])
                    2'b01:   csr_mem[csr_addr] <= csr_wdata;
                    2'b10:   csr_mem[csr_addr] <= csr_mem[csr_addr] | csr_wdata;
                    2'b11:   csr_mem[csr_addr] <= csr_mem[csr_addr] & ~csr_wdata;
                    default: csr_mem[csr_addr] <= csr_mem[csr_addr];
                endcase
            end
        end
    end

    typedef struct {
        logic [63:0] rdata;
        logic        redir;
        logic [63:0] rpc;
        logic        ill;
        logic        to;
        logic [3:0]  addr;
        logic [2:0]  f3;
        logic [63:0] wdata;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] sh [0:15];
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one instruction, follow it through the handshake, check the result.
    task automatic run_op(input string tag, input logic [63:0] pc, input logic [2:0] f3,
                          input logic [11:0] csr, input logic [63:0] rs1, input logic [4:0] zimm,
                          input logic ec, input logic mr, input int rdy_delay,
                          input int exp_lat, input int hold);
        exp_t e;
        logic [3:0] idx;
        logic hit;
        int lat;
        int en_n;
        int ack_n;
        bit got;

        hit = 1'b1;
        case (csr)
            12'h300: idx = 4'd1;
            12'h304: idx = 4'd2;
            12'h305: idx = 4'd3;
            12'h341: idx = 4'd4;
            12'h342: idx = 4'd5;
            12'h344: idx = 4'd6;
            default: begin idx = 4'd0; hit = 1'b0; end
        endcase
        e.rdata = '0; e.redir = 1'b0; e.rpc = '0; e.ill = 1'b0; e.to = 1'b0;
        e.addr  = idx;
        e.f3    = f3;
        e.wdata = f3[2] ? {59'd0, zimm} : rs1;
        if (ec) begin
            e.addr = 4'd10; e.f3 = 3'b000; e.redir = 1'b1; e.rpc = sh[3]; sh[4] = pc;
        end else if (mr) begin
            e.addr = 4'd11; e.f3 = 3'b000; e.redir = 1'b1; e.rpc = sh[4];
        end else if (f3 == 3'b000 || !hit) begin
            e.ill = 1'b1;
        end else if (rdy_delay >= 1000) begin
            e.to = 1'b1;
        end else begin
            e.rdata = sh[idx];
            case (f3[1:0])
                2'b01:   sh[idx] = e.wdata;
                2'b10:   sh[idx] = sh[idx] | e.wdata;
                2'b11:   sh[idx] = sh[idx] & ~e.wdata;
                default: sh[idx] = sh[idx];
            endcase
        end
        sb.push_back(e);

        chk({tag, "/in_ready"}, in_ready, 1);
        resp_en  = (rdy_delay == 0);
        in_valid = 1'b1; in_pc = pc; in_func3 = f3; in_csr = csr;
        in_rs1 = rs1; in_zimm = zimm; in_ecall = ec; in_mret = mr;
        @(posedge clk);
        #1 in_valid = 1'b0;

        lat = 0; en_n = 0; ack_n = 0; got = 1'b0;
        while (lat < 64) begin
            @(negedge clk);
            lat++;
            if (csr_en) begin
                en_n++;
                chk({tag, "/csr_addr"},  csr_addr,  sb[0].addr);
                chk({tag, "/csr_func3"}, csr_func3, sb[0].f3);
                chk({tag, "/csr_wdata"}, csr_wdata, sb[0].wdata);
                chk({tag, "/csr_pc"},    csr_pc,    pc);
            end
            if (csr_valid) ack_n++;
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            if (lat == rdy_delay) resp_en = 1'b1;
        end

        e = sb.pop_front();
        chk({tag, "/out_valid_seen"}, got, 1);
        chk({tag, "/latency"}, lat, exp_lat);
        chk({tag, "/en_cycles"}, en_n, e.ill ? 0 : exp_lat - 1);
        chk({tag, "/ack_cycles"}, ack_n, (e.ill || e.to) ? 0 : 1);
        chk({tag, "/out_rdata"},    out_rdata,    e.rdata);
        chk({tag, "/out_redir"},    out_redir,    e.redir);
        chk({tag, "/out_redir_pc"}, out_redir_pc, e.rpc);
        chk({tag, "/out_illegal"},  out_illegal,  e.ill);
        chk({tag, "/out_timeout"},  out_timeout,  e.to);
        chk({tag, "/done_csr_en"},  csr_en,       0);

        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({tag, "/hold_valid"},    out_valid,    1);
            chk({tag, "/hold_in_ready"}, in_ready,     0);
            chk({tag, "/hold_rdata"},    out_rdata,    e.rdata);
            chk({tag, "/hold_redir_pc"}, out_redir_pc, e.rpc);
            chk({tag, "/hold_illegal"},  out_illegal,  e.ill);
        end

        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        resp_en = 1'b1;
        @(negedge clk);
        chk({tag, "/idle_in_ready"},  in_ready,  1);
        chk({tag, "/idle_out_valid"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) sh[i] = 64'd0;
        sh[1] = 64'ha00001800;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst/in_ready",     in_ready,     1);
        chk("rst/out_valid",    out_valid,    0);
        chk("rst/csr_en",       csr_en,       0);
        chk("rst/csr_valid",    csr_valid,    0);
        chk("rst/csr_addr",     csr_addr,     0);
        chk("rst/csr_wdata",    csr_wdata,    0);
        chk("rst/out_rdata",    out_rdata,    0);
        chk("rst/out_redir",    out_redir,    0);
        chk("rst/out_illegal",  out_illegal,  0);
        chk("rst/out_timeout",  out_timeout,  0);
        rst_n = 1'b1;
        mem_init = 1'b0;
        @(negedge clk);

        //      tag         pc              f3      csr      rs1             zimm  ec    mr    dly   lat hold
        run_op("mtvec_w",   64'h80000000,   3'b001, 12'h305, 64'h80000100,   5'd0, 1'b0, 1'b0, 0,    3,  0);
        run_op("mstat_si",  64'h80000004,   3'b110, 12'h300, 64'h0,          5'd8, 1'b0, 1'b0, 0,    3,  5);
        run_op("mstat_ci",  64'h80000008,   3'b111, 12'h300, 64'hffff,       5'd8, 1'b0, 1'b0, 0,    3,  0);
        run_op("ecall",     64'h80000040,   3'b000, 12'h000, 64'h0,          5'd0, 1'b1, 1'b0, 0,    3,  0);
        run_op("mret",      64'h80000100,   3'b000, 12'h302, 64'h0,          5'd0, 1'b0, 1'b1, 0,    3,  0);
        run_op("ill_f14",   64'h80000044,   3'b001, 12'hf14, 64'h1234,       5'd0, 1'b0, 1'b0, 0,    1,  2);
        run_op("ill_sys",   64'h80000048,   3'b000, 12'h300, 64'h0,          5'd0, 1'b0, 1'b0, 0,    1,  0);
        run_op("ec_mret",   64'h80000200,   3'b000, 12'h000, 64'h0,          5'd0, 1'b1, 1'b1, 0,    3,  0);
        run_op("mepc_slow", 64'h8000004c,   3'b010, 12'h341, 64'h5,          5'd0, 1'b0, 1'b0, 4,    6,  0);
        run_op("timeout",   64'h80000050,   3'b001, 12'h342, 64'hdead,       5'd0, 1'b0, 1'b0, 1000, 17, 0);
        run_op("mcause_rd", 64'h80000054,   3'b010, 12'h342, 64'h0,          5'd0, 1'b0, 1'b0, 0,    3,  0);
        run_op("mie_w",     64'h80000058,   3'b001, 12'h304, 64'h888,        5'd0, 1'b0, 1'b0, 0,    3,  0);
        run_op("mip_c",     64'h8000005c,   3'b011, 12'h344, 64'hff,         5'd0, 1'b0, 1'b0, 2,    4,  0);

        // Reset while the request is outstanding: nothing may come out.
        resp_en = 1'b0;
        in_valid = 1'b1; in_pc = 64'h80000060; in_func3 = 3'b001; in_csr = 12'h304;
        in_rs1 = 64'h55; in_zimm = 5'd0; in_ecall = 1'b0; in_mret = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("midrst/in_req", csr_en, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst/csr_en",    csr_en,    0);
        chk("midrst/in_ready",  in_ready,  1);
        chk("midrst/out_valid", out_valid, 0);
        chk("midrst/csr_addr",  csr_addr,  0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        resp_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst/no_out_valid", out_valid, 0);
            chk("midrst/no_csr_en",    csr_en,    0);
        end

        run_op("mie_rd",    64'h80000064,   3'b010, 12'h304, 64'h0,          5'd0, 1'b0, 1'b0, 0,    3,  0);
        run_op("mepc_rd",   64'h80000068,   3'b010, 12'h341, 64'h0,          5'd0, 1'b0, 1'b0, 0,    3,  0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
